id_stage_ctrl: RTL and testbench

- Decode-stage pipeline register and control, placed between the fetch stage and the execute stage.
- Holds the instruction in ID and runs the valid/allowin handshake with its neighbours.
- Consumes the ID-stage operand values (rs/rt) and the stall flag produced by the operand-forwarding logic.
- Resolves branches and jumps in ID and tracks the branch-delay-slot flag; a pipeline flush kills the held instruction.

---
 rtl/id_stage_ctrl.sv | 162 ++++++++++++++++
 tb/tb_id_stage_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_ctrl.sv
// -----------------------------------------------------------------------------
// id_stage_ctrl
// Decode-stage pipeline register and control. Holds the instruction in ID,
// runs the valid/allowin handshake with IF and EX, resolves branches/jumps
// using the forwarded rs/rt operands, and tracks the branch-delay-slot flag.
// A flush from WB kills whatever ID holds.
// -----------------------------------------------------------------------------
module id_stage_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  // fetch side
  input  logic        fs_to_ds_valid,
  input  logic [31:0] fs_pc,
  input  logic [31:0] fs_inst,
  output logic        ds_allowin,
  // held instruction
  output logic        ds_valid,
  output logic [31:0] ds_pc,
  output logic [31:0] ds_inst,
  // decoder / forwarding inputs
  input  logic [3:0]  br_type,
  input  logic        ds_stall,
  input  logic [31:0] rs_value,
  input  logic [31:0] rt_value,
  // execute side
  input  logic        es_allowin,
  output logic        ds_to_es_valid,
  // branch resolution
  output logic        ds_in_bd,
  output logic        br_taken,
  output logic [31:0] br_target,
  output logic        br_stall
);

  localparam logic [3:0] BR_NONE = 4'd0;
  localparam logic [3:0] BR_BEQ  = 4'd1;
  localparam logic [3:0] BR_BNE  = 4'd2;
  localparam logic [3:0] BR_BGEZ = 4'd3;
  localparam logic [3:0] BR_BGTZ = 4'd4;
  localparam logic [3:0] BR_BLEZ = 4'd5;
  localparam logic [3:0] BR_BLTZ = 4'd6;
  localparam logic [3:0] BR_J    = 4'd7;
  localparam logic [3:0] BR_JR   = 4'd8;

  logic        ds_valid_r;
  logic [31:0] ds_pc_r;
  logic [31:0] ds_inst_r;
  logic        bd_flag_r;

  logic        ready_go_s;
  logic        allowin_s;
  logic        leave_s;
  logic        is_branch_s;
  logic        cond_true_s;
  logic [31:0] target_s;
  logic [31:0] pc4_s;
  logic [31:0] br_off_s;
  logic        rs_neg_s;
  logic        rs_zero_s;

  // Handshake: ID may go when forwarding does not stall it; it leaves only
  // when EX accepts and no flush is killing it.
  assign ready_go_s = ~ds_stall;
  assign allowin_s  = ~ds_valid_r | (ready_go_s & es_allowin);
  assign leave_s    = ds_valid_r & ready_go_s & es_allowin & ~flush;

  // Any encoded branch or jump (1..8) opens a delay slot; 9-15 decode as none.
  assign is_branch_s = (br_type >= BR_BEQ) && (br_type <= BR_JR);

  assign pc4_s     = ds_pc_r + 32'd4;
  assign br_off_s  = {{14{ds_inst_r[15]}}, ds_inst_r[15:0], 2'b00};
  assign rs_neg_s  = rs_value[31];
  assign rs_zero_s = (rs_value == 32'd0);

  // Branch condition and target selection by branch type.
  always_comb begin
    cond_true_s = 1'b0;
    target_s    = pc4_s + br_off_s;
    case (br_type)
      BR_NONE: begin
        cond_true_s = 1'b0;
      end
      BR_BEQ: begin
        cond_true_s = (rs_value == rt_value);
      end
      BR_BNE: begin
        cond_true_s = (rs_value != rt_value);
      end
      BR_BGEZ: begin
        cond_true_s = ~rs_neg_s;
      end
      BR_BGTZ: begin
        cond_true_s = ~rs_neg_s & ~rs_zero_s;
      end
      BR_BLEZ: begin
        cond_true_s = rs_neg_s | rs_zero_s;
      end
      BR_BLTZ: begin
        cond_true_s = rs_neg_s;
      end
      BR_J: begin
        cond_true_s = 1'b1;
        target_s    = {pc4_s[31:28], ds_inst_r[25:0], 2'b00};
      end
      BR_JR: begin
        cond_true_s = 1'b1;
        target_s    = rs_value;
      end
      default: begin
        cond_true_s = 1'b0;
      end
    endcase
  end

  // Valid bit: flush kills, otherwise refill from IF whenever ID can accept.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ds_valid_r <= 1'b0;
    end else if (flush) begin
      ds_valid_r <= 1'b0;
    end else if (allowin_s) begin
      ds_valid_r <= fs_to_ds_valid;
    end
  end

  // Instruction payload: captured only when a real instruction enters ID.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ds_pc_r   <= RESET_PC;
      ds_inst_r <= 32'd0;
    end else if (!flush && allowin_s && fs_to_ds_valid) begin
      ds_pc_r   <= fs_pc;
      ds_inst_r <= fs_inst;
    end
  end

  // Delay-slot flag: set by a branch leaving ID and kept across bubbles until
  // the next instruction leaves; flush clears it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bd_flag_r <= 1'b0;
    end else if (flush) begin
      bd_flag_r <= 1'b0;
    end else if (leave_s) begin
      bd_flag_r <= is_branch_s;
    end
  end

  assign ds_allowin     = allowin_s;
  assign ds_valid       = ds_valid_r;
  assign ds_pc          = ds_pc_r;
  assign ds_inst        = ds_inst_r;
  assign ds_to_es_valid = ds_valid_r & ready_go_s & ~flush;
  assign ds_in_bd       = ds_valid_r & bd_flag_r;
  assign br_taken       = leave_s & cond_true_s;
  assign br_target      = target_s;
  assign br_stall       = ds_valid_r & is_branch_s & ds_stall;

endmodule

// File: tb/tb_id_stage_ctrl.sv
// -----------------------------------------------------------------------------
// tb_id_stage_ctrl
// Table-driven bench for id_stage_ctrl: one record per clock cycle with the
// inputs to drive and the outputs expected before the next rising edge, a
// condition table exercised while the held instruction is stalled, and a
// hand-written reset-during-stall sequence.
// -----------------------------------------------------------------------------
module tb_id_stage_ctrl;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic        clk;
  logic        resetn;
  logic        flush;
  logic        fs_to_ds_valid;
  logic [31:0] fs_pc;
  logic [31:0] fs_inst;
  logic        ds_allowin;
  logic        ds_valid;
  logic [31:0] ds_pc;
  logic [31:0] ds_inst;
  logic [3:0]  br_type;
  logic        ds_stall;
  logic [31:0] rs_value;
  logic [31:0] rt_value;
  logic        es_allowin;
  logic        ds_to_es_valid;
  logic        ds_in_bd;
  logic        br_taken;
  logic [31:0] br_target;
  logic        br_stall;

  int n_checks = 0;
  int n_fail   = 0;

  id_stage_ctrl #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .flush          (flush),
    .fs_to_ds_valid (fs_to_ds_valid),
    .fs_pc          (fs_pc),
    .fs_inst        (fs_inst),
    .ds_allowin     (ds_allowin),
    .ds_valid       (ds_valid),
    .ds_pc          (ds_pc),
    .ds_inst        (ds_inst),
    .br_type        (br_type),
    .ds_stall       (ds_stall),
    .rs_value       (rs_value),
    .rt_value       (rt_value),
    .es_allowin     (es_allowin),
    .ds_to_es_valid (ds_to_es_valid),
    .ds_in_bd       (ds_in_bd),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .br_stall       (br_stall)
  );

  // 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        fv;
    logic [31:0] fpc;
    logic [31:0] finst;
    logic [3:0]  bt;
    logic        st;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        ea;
    logic        fl;
    logic        chk_data;
    logic        v;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        alw;
    logic        tev;
    logic        bd;
    logic        bk;
    logic [31:0] tgt;
    logic        bs;
  } vec_t;

  typedef struct {
    logic [3:0]  bt;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        bk;
    logic [31:0] tgt;
  } cvec_t;

  vec_t  tbl[$];
  cvec_t ctbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic fv, input logic [31:0] fpc, input logic [31:0] finst,
    input logic [3:0] bt, input logic st, input logic [31:0] rs, input logic [31:0] rt,
    input logic ea, input logic fl, input logic cd,
    input logic v, input logic [31:0] pc, input logic [31:0] inst,
    input logic alw, input logic tev, input logic bd, input logic bk,
    input logic [31:0] tgt, input logic bs);
    vec_t r;
    r.fv = fv; r.fpc = fpc; r.finst = finst; r.bt = bt; r.st = st;
    r.rs = rs; r.rt = rt; r.ea = ea; r.fl = fl; r.chk_data = cd;
    r.v = v; r.pc = pc; r.inst = inst; r.alw = alw; r.tev = tev;
    r.bd = bd; r.bk = bk; r.tgt = tgt; r.bs = bs;
    return r;
  endfunction

  function automatic cvec_t mkc(input logic [3:0] bt, input logic [31:0] rs,
                                input logic [31:0] rt, input logic bk, input logic [31:0] tgt);
    cvec_t c;
    c.bt = bt; c.rs = rs; c.rt = rt; c.bk = bk; c.tgt = tgt;
    return c;
  endfunction

  initial begin
    // ---------------------------------------------------------------- tables
    //            fv   fpc           finst         bt   st   rs            rt    ea   fl   cd    v    pc            inst          alw  tev  bd   bk   tgt           bs
    tbl.push_back(mk(1, 32'h0000_0100, 32'h0085_1020, 4'd0, 0, 32'd0,        32'd0, 1, 0, 1,   0, RST_PC,        32'h0000_0000, 1, 0, 0, 0, 32'd0,         0)); // r0 load
    tbl.push_back(mk(1, 32'h0000_1000, 32'h1085_FFFE, 4'd0, 1, 32'd0,        32'd0, 1, 0, 1,   1, 32'h0000_0100, 32'h0085_1020, 0, 0, 0, 0, 32'd0,         0)); // r1 stall
    tbl.push_back(mk(1, 32'h0000_1000, 32'h1085_FFFE, 4'd0, 1, 32'd0,        32'd0, 1, 0, 1,   1, 32'h0000_0100, 32'h0085_1020, 0, 0, 0, 0, 32'd0,         0)); // r2 stall
    tbl.push_back(mk(1, 32'h0000_1000, 32'h1085_FFFE, 4'd0, 0, 32'd0,        32'd0, 1, 0, 1,   1, 32'h0000_0100, 32'h0085_1020, 1, 1, 0, 0, 32'd0,         0)); // r3 release
    tbl.push_back(mk(1, 32'h0000_1004, 32'h0000_0000, 4'd1, 0, 32'd5,        32'd5, 1, 0, 1,   1, 32'h0000_1000, 32'h1085_FFFE, 1, 1, 0, 1, 32'h0000_0FFC, 0)); // r4 beq taken
    tbl.push_back(mk(0, 32'd0,         32'd0,         4'd0, 0, 32'd0,        32'd0, 1, 0, 1,   1, 32'h0000_1004, 32'h0000_0000, 1, 1, 1, 0, 32'd0,         0)); // r5 delay slot
    tbl.push_back(mk(1, 32'h0000_2000, 32'h0480_0010, 4'd0, 0, 32'd0,        32'd0, 1, 0, 1,   0, 32'h0000_1004, 32'h0000_0000, 1, 0, 0, 0, 32'd0,         0)); // r6 bubble
    tbl.push_back(mk(0, 32'd0,         32'd0,         4'd6, 0, 32'd0,        32'd0, 1, 0, 1,   1, 32'h0000_2000, 32'h0480_0010, 1, 1, 0, 0, 32'd0,         0)); // r7 bltz not taken
    tbl.push_back(mk(0, 32'd0,         32'd0,         4'd0, 0, 32'd0,        32'd0, 1, 0, 1,   0, 32'h0000_2000, 32'h0480_0010, 1, 0, 0, 0, 32'd0,         0)); // r8 bubble
    tbl.push_back(mk(1, 32'h0000_2004, 32'h0000_0000, 4'd0, 0, 32'd0,        32'd0, 1, 0, 1,   0, 32'h0000_2000, 32'h0480_0010, 1, 0, 0, 0, 32'd0,         0)); // r9 bubble, load slot
    tbl.push_back(mk(0, 32'd0,         32'd0,         4'd0, 0, 32'd0,        32'd0, 1, 0, 1,   1, 32'h0000_2004, 32'h0000_0000, 1, 1, 1, 0, 32'd0,         0)); // r10 slot after bubbles
    tbl.push_back(mk(1, 32'h0000_3000, 32'h0080_0008, 4'd0, 0, 32'd0,        32'd0, 1, 0, 1,   0, 32'h0000_2004, 32'h0000_0000, 1, 0, 0, 0, 32'd0,         0)); // r11 load jr
    tbl.push_back(mk(1, 32'h0000_3004, 32'h0000_0000, 4'd8, 1, 32'h8000_0040, 32'd0, 1, 0, 1,  1, 32'h0000_3000, 32'h0080_0008, 0, 0, 0, 0, 32'd0,         1)); // r12 jr stalled
    tbl.push_back(mk(1, 32'h0000_3004, 32'h0000_0000, 4'd8, 0, 32'h8000_0040, 32'd0, 1, 0, 1,  1, 32'h0000_3000, 32'h0080_0008, 1, 1, 0, 1, 32'h8000_0040, 0)); // r13 jr release
    tbl.push_back(mk(1, 32'hA000_3008, 32'h0800_0010, 4'd0, 0, 32'd0,        32'd0, 1, 0, 1,   1, 32'h0000_3004, 32'h0000_0000, 1, 1, 1, 0, 32'd0,         0)); // r14 jr slot
    tbl.push_back(mk(0, 32'd0,         32'd0,         4'd7, 0, 32'd0,        32'd0, 1, 0, 1,   1, 32'hA000_3008, 32'h0800_0010, 1, 1, 0, 1, 32'hA000_0040, 0)); // r15 j
    tbl.push_back(mk(1, 32'h0000_4000, 32'h00A6_3820, 4'd0, 0, 32'd0,        32'd0, 1, 0, 1,   0, 32'hA000_3008, 32'h0800_0010, 1, 0, 0, 0, 32'd0,         0)); // r16 load slot
    tbl.push_back(mk(1, 32'h0000_4004, 32'h1485_0003, 4'd0, 0, 32'd0,        32'd0, 0, 0, 1,   1, 32'h0000_4000, 32'h00A6_3820, 0, 1, 1, 0, 32'd0,         0)); // r17 EX backpressure
    tbl.push_back(mk(1, 32'h0000_4004, 32'h1485_0003, 4'd0, 0, 32'd0,        32'd0, 0, 0, 1,   1, 32'h0000_4000, 32'h00A6_3820, 0, 1, 1, 0, 32'd0,         0)); // r18
    tbl.push_back(mk(1, 32'h0000_4004, 32'h1485_0003, 4'd0, 0, 32'd0,        32'd0, 0, 0, 1,   1, 32'h0000_4000, 32'h00A6_3820, 0, 1, 1, 0, 32'd0,         0)); // r19
    tbl.push_back(mk(1, 32'h0000_4004, 32'h1485_0003, 4'd0, 0, 32'd0,        32'd0, 1, 0, 1,   1, 32'h0000_4000, 32'h00A6_3820, 1, 1, 1, 0, 32'd0,         0)); // r20 EX accepts
    tbl.push_back(mk(1, 32'h0000_4008, 32'h0000_0000, 4'd2, 0, 32'd1,        32'd2, 0, 0, 1,   1, 32'h0000_4004, 32'h1485_0003, 0, 1, 0, 0, 32'd0,         0)); // r21 bne held by EX
    tbl.push_back(mk(1, 32'h0000_4008, 32'h0000_0000, 4'd2, 0, 32'd1,        32'd2, 1, 0, 1,   1, 32'h0000_4004, 32'h1485_0003, 1, 1, 0, 1, 32'h0000_4014, 0)); // r22 bne taken
    tbl.push_back(mk(1, 32'h0000_5000, 32'hDEAD_BEEF, 4'd0, 0, 32'd0,        32'd0, 1, 1, 1,   1, 32'h0000_4008, 32'h0000_0000, 1, 0, 1, 0, 32'd0,         0)); // r23 flush slot
    tbl.push_back(mk(1, 32'h0000_6000, 32'h0000_0001, 4'd0, 0, 32'd0,        32'd0, 1, 0, 0,   0, 32'd0,         32'd0,         1, 0, 0, 0, 32'd0,         0)); // r24 empty after flush
    tbl.push_back(mk(0, 32'd0,         32'd0,         4'd0, 0, 32'd0,        32'd0, 1, 0, 1,   1, 32'h0000_6000, 32'h0000_0001, 1, 1, 0, 0, 32'd0,         0)); // r25 no stale bd
    tbl.push_back(mk(1, 32'h0000_7000, 32'h1000_0005, 4'd0, 0, 32'd0,        32'd0, 1, 0, 1,   0, 32'h0000_6000, 32'h0000_0001, 1, 0, 0, 0, 32'd0,         0)); // r26 load beq
    tbl.push_back(mk(1, 32'h0000_7004, 32'hCAFE_F00D, 4'd1, 0, 32'd0,        32'd0, 1, 1, 1,   1, 32'h0000_7000, 32'h1000_0005, 1, 0, 0, 0, 32'd0,         0)); // r27 flush on branch
    tbl.push_back(mk(0, 32'd0,         32'd0,         4'd0, 0, 32'd0,        32'd0, 1, 0, 0,   0, 32'd0,         32'd0,         1, 0, 0, 0, 32'd0,         0)); // r28 empty

    // Held inst 0x00851020 at pc 0x100: pc4=0x104, imm=0x1020 -> 0x4184;
    // j target {0x0, 0x0851020<<2} = 0x02144080.
    ctbl.push_back(mkc(4'd1,  32'd7,         32'd7, 1, 32'h0000_4184));
    ctbl.push_back(mkc(4'd1,  32'd7,         32'd8, 0, 32'd0));
    ctbl.push_back(mkc(4'd2,  32'd7,         32'd8, 1, 32'h0000_4184));
    ctbl.push_back(mkc(4'd2,  32'd3,         32'd3, 0, 32'd0));
    ctbl.push_back(mkc(4'd3,  32'd0,         32'd0, 1, 32'h0000_4184));
    ctbl.push_back(mkc(4'd3,  32'hFFFF_FFFF, 32'd0, 0, 32'd0));
    ctbl.push_back(mkc(4'd4,  32'd0,         32'd0, 0, 32'd0));
    ctbl.push_back(mkc(4'd4,  32'd1,         32'd0, 1, 32'h0000_4184));
    ctbl.push_back(mkc(4'd4,  32'h8000_0000, 32'd0, 0, 32'd0));
    ctbl.push_back(mkc(4'd5,  32'd0,         32'd0, 1, 32'h0000_4184));
    ctbl.push_back(mkc(4'd5,  32'd1,         32'd0, 0, 32'd0));
    ctbl.push_back(mkc(4'd5,  32'hFFFF_FFFF, 32'd0, 1, 32'h0000_4184));
    ctbl.push_back(mkc(4'd6,  32'h8000_0000, 32'd0, 1, 32'h0000_4184));
    ctbl.push_back(mkc(4'd6,  32'h7FFF_FFFF, 32'd0, 0, 32'd0));
    ctbl.push_back(mkc(4'd0,  32'd5,         32'd5, 0, 32'd0));
    ctbl.push_back(mkc(4'd9,  32'd5,         32'd5, 0, 32'd0));
    ctbl.push_back(mkc(4'd15, 32'd5,         32'd5, 0, 32'd0));
    ctbl.push_back(mkc(4'd7,  32'd0,         32'd0, 1, 32'h0214_4080));
    ctbl.push_back(mkc(4'd8,  32'h1234_5678, 32'd0, 1, 32'h1234_5678));

    // ---------------------------------------------------------------- reset
    resetn = 1'b0; flush = 1'b0; fs_to_ds_valid = 1'b0; fs_pc = 32'd0; fs_inst = 32'd0;
    br_type = 4'd0; ds_stall = 1'b0; rs_value = 32'd0; rt_value = 32'd0; es_allowin = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset ds_valid", {31'd0, ds_valid}, 32'd0);
    chk("reset ds_pc", ds_pc, RST_PC);
    chk("reset ds_inst", ds_inst, 32'd0);
    chk("reset ds_to_es_valid", {31'd0, ds_to_es_valid}, 32'd0);
    chk("reset ds_in_bd", {31'd0, ds_in_bd}, 32'd0);
    chk("reset br_taken", {31'd0, br_taken}, 32'd0);
    chk("reset br_stall", {31'd0, br_stall}, 32'd0);
    resetn = 1'b1;

    // ---------------------------------------------------------------- main table
    for (int i = 0; i < tbl.size(); i++) begin
      if (i != 0) @(negedge clk);
      fs_to_ds_valid = tbl[i].fv; fs_pc = tbl[i].fpc; fs_inst = tbl[i].finst;
      br_type = tbl[i].bt; ds_stall = tbl[i].st; rs_value = tbl[i].rs; rt_value = tbl[i].rt;
      es_allowin = tbl[i].ea; flush = tbl[i].fl;
      #2;
      chk($sformatf("row%0d ds_valid", i), {31'd0, ds_valid}, {31'd0, tbl[i].v});
      if (tbl[i].chk_data) begin
        chk($sformatf("row%0d ds_pc", i), ds_pc, tbl[i].pc);
        chk($sformatf("row%0d ds_inst", i), ds_inst, tbl[i].inst);
      end
      chk($sformatf("row%0d ds_allowin", i), {31'd0, ds_allowin}, {31'd0, tbl[i].alw});
      chk($sformatf("row%0d ds_to_es_valid", i), {31'd0, ds_to_es_valid}, {31'd0, tbl[i].tev});
      chk($sformatf("row%0d ds_in_bd", i), {31'd0, ds_in_bd}, {31'd0, tbl[i].bd});
      chk($sformatf("row%0d br_taken", i), {31'd0, br_taken}, {31'd0, tbl[i].bk});
      if (tbl[i].bk) chk($sformatf("row%0d br_target", i), br_target, tbl[i].tgt);
      chk($sformatf("row%0d br_stall", i), {31'd0, br_stall}, {31'd0, tbl[i].bs});
    end

    // ---------------------------------------------------------------- condition table
    // Load 0x00851020 at pc 0x100, then evaluate each condition while ID is
    // released for part of the cycle and stalled again before the clock edge.
    @(negedge clk);
    flush = 1'b0; fs_to_ds_valid = 1'b1; fs_pc = 32'h0000_0100; fs_inst = 32'h0085_1020;
    br_type = 4'd0; ds_stall = 1'b0; es_allowin = 1'b1;
    @(negedge clk);
    fs_to_ds_valid = 1'b0; ds_stall = 1'b1;
    for (int i = 0; i < ctbl.size(); i++) begin
      @(negedge clk);
      br_type = ctbl[i].bt; rs_value = ctbl[i].rs; rt_value = ctbl[i].rt; ds_stall = 1'b0;
      #2;
      chk($sformatf("cond%0d br_taken bt=%0d", i, ctbl[i].bt), {31'd0, br_taken}, {31'd0, ctbl[i].bk});
      if (ctbl[i].bk) chk($sformatf("cond%0d br_target", i), br_target, ctbl[i].tgt);
      ds_stall = 1'b1;
      #1;
      chk($sformatf("cond%0d stalled br_taken", i), {31'd0, br_taken}, 32'd0);
    end
    chk("cond hold ds_pc", ds_pc, 32'h0000_0100);

    // ---------------------------------------------------------------- reset mid-stall
    // j leaves (bd set), delay slot arrives and stalls as a branch; reset then hits.
    @(negedge clk);
    br_type = 4'd7; ds_stall = 1'b0; es_allowin = 1'b1;
    fs_to_ds_valid = 1'b1; fs_pc = 32'h0000_0104; fs_inst = 32'h0000_0000;
    @(negedge clk);
    fs_to_ds_valid = 1'b0; br_type = 4'd8; ds_stall = 1'b1; rs_value = 32'h0000_0200;
    #2;
    chk("pre-reset ds_in_bd", {31'd0, ds_in_bd}, 32'd1);
    chk("pre-reset br_stall", {31'd0, br_stall}, 32'd1);
    chk("pre-reset ds_pc", ds_pc, 32'h0000_0104);
    resetn = 1'b0;
    #1;
    chk("midreset ds_valid", {31'd0, ds_valid}, 32'd0);
    chk("midreset ds_in_bd", {31'd0, ds_in_bd}, 32'd0);
    chk("midreset br_stall", {31'd0, br_stall}, 32'd0);
    chk("midreset br_taken", {31'd0, br_taken}, 32'd0);
    chk("midreset ds_pc", ds_pc, RST_PC);
    ds_stall = 1'b0;
    #1;
    chk("midreset release br_taken", {31'd0, br_taken}, 32'd0);
    chk("midreset ds_to_es_valid", {31'd0, ds_to_es_valid}, 32'd0);
    @(negedge clk);
    resetn = 1'b1; br_type = 4'd0;
    @(negedge clk);
    chk("post-reset ds_valid", {31'd0, ds_valid}, 32'd0);
    chk("post-reset ds_inst", ds_inst, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
